// File: rtl/external_irq_arbiter_if.sv
// rtl/external_irq_arbiter_if.sv - external interrupt handshake between the arbiter and the interrupt controller

interface external_irq_arbiter_if;
    logic       ext_active;
    logic [5:0] ext_num;
    logic       ext_ack;

    modport master (
        output ext_active,
        output ext_num,
        input  ext_ack
    );

    modport slave (
        input  ext_active,
        input  ext_num,
        output ext_ack
    );
endinterface

// File: rtl/external_irq_arbiter.sv
// rtl/external_irq_arbiter.sv - synchronises and latches device IRQ lines, presents the lowest-index
// enabled pending source to the interrupt controller and holds it until acknowledged

module external_irq_arbiter #(
    parameter int                 NUM_SRC    = 32,
    parameter logic [NUM_SRC-1:0] EDGE_SENSE = '0
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic               iRESET_SYNC,
    input  logic [NUM_SRC-1:0] iIRQ_REQ,
    input  logic [NUM_SRC-1:0] iIRQ_ENABLE,
    output logic [NUM_SRC-1:0] oIRQ_PENDING,
    output logic [NUM_SRC-1:0] oIRQ_CLEAR,
    external_irq_arbiter_if.master ext
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [NUM_SRC-1:0] req_meta;
    logic [NUM_SRC-1:0] req_sync;
    logic [NUM_SRC-1:0] req_sync_d;
    logic [NUM_SRC-1:0] pend_edge;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] num_onehot;
    logic [NUM_SRC-1:0] accept_vec;
    logic [NUM_SRC-1:0] clear_q;

    logic [5:0] win_num;
    logic       win_valid;
    logic [5:0] b_num;
    logic       hold_cnt;

    logic ext_active_c;
    logic take_ack;
    logic load_num;
    logic in_holdoff;

    // Two-flop synchroniser plus one delayed copy for rising-edge detection.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            req_meta   <= '0;
            req_sync   <= '0;
            req_sync_d <= '0;
        end else if (iRESET_SYNC) begin
            req_meta   <= '0;
            req_sync   <= '0;
            req_sync_d <= '0;
        end else begin
            req_meta   <= iIRQ_REQ;
            req_sync   <= req_meta;
            req_sync_d <= req_sync;
        end
    end

    assign edge_set = req_sync & ~req_sync_d & EDGE_SENSE;

    // A fresh edge in the same cycle as the acceptance clear must survive.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            pend_edge <= '0;
        end else if (iRESET_SYNC) begin
            pend_edge <= '0;
        end else begin
            pend_edge <= (pend_edge & ~accept_vec) | edge_set;
        end
    end

    assign pending = pend_edge | (req_sync & ~EDGE_SENSE);
    assign cand    = pending & iIRQ_ENABLE;

    always_comb begin
        win_num   = '0;
        win_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_num   = 6'(i);
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        num_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            num_onehot[i] = (b_num == 6'(i));
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state <= ST_IDLE;
        end else if (iRESET_SYNC) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:    state_nxt = win_valid ? ST_REQ : ST_IDLE;
            ST_REQ:     state_nxt = ext.ext_ack ? ST_HOLDOFF : ST_REQ;
            ST_HOLDOFF: state_nxt = hold_cnt ? ST_IDLE : ST_HOLDOFF;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ext_active_c = 1'b0;
        take_ack     = 1'b0;
        load_num     = 1'b0;
        in_holdoff   = 1'b0;
        case (state)
            ST_IDLE: begin
                load_num = win_valid;
            end
            ST_REQ: begin
                ext_active_c = 1'b1;
                take_ack     = ext.ext_ack;
            end
            ST_HOLDOFF: begin
                in_holdoff = 1'b1;
            end
            default: begin
                ext_active_c = 1'b0;
            end
        endcase
    end

    assign accept_vec = take_ack ? num_onehot : '0;

    // b_num is frozen outside IDLE, which keeps a committed request stable.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            b_num    <= '0;
            hold_cnt <= 1'b0;
            clear_q  <= '0;
        end else if (iRESET_SYNC) begin
            b_num    <= '0;
            hold_cnt <= 1'b0;
            clear_q  <= '0;
        end else begin
            if (load_num) begin
                b_num <= win_num;
            end
            hold_cnt <= in_holdoff ? ~hold_cnt : 1'b0;
            clear_q  <= accept_vec;
        end
    end

    assign ext.ext_active = ext_active_c;
    assign ext.ext_num    = b_num;
    assign oIRQ_PENDING   = pending;
    assign oIRQ_CLEAR     = clear_q;

endmodule

// File: tb/tb_external_irq_arbiter.sv
// tb/tb_external_irq_arbiter.sv - directed scoreboard bench for external_irq_arbiter

module tb_external_irq_arbiter;

    localparam int          NUM_SRC   = 16;
    localparam logic [15:0] EDGE_MASK = 16'h02A8;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rst_sync = 1'b0;
    logic [15:0] irq_req  = '0;
    logic [15:0] irq_en   = '1;
    logic [15:0] pending;
    logic [15:0] clear;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    external_irq_arbiter_if ext_if ();

    external_irq_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .EDGE_SENSE (EDGE_MASK)
    ) dut (
        .iCLOCK       (clk),
        .iRESET       (rst),
        .iRESET_SYNC  (rst_sync),
        .iIRQ_REQ     (irq_req),
        .iIRQ_ENABLE  (irq_en),
        .oIRQ_PENDING (pending),
        .oIRQ_CLEAR   (clear),
        .ext          (ext_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_active(input int budget, output int n);
        n = 0;
        while (ext_if.ext_active !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("active_timeout", 64'(ext_if.ext_active), 64'd1);
    endtask

    task automatic check_grant(input string tag);
        int e;
        chk({tag, "_queue"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, 64'(ext_if.ext_num), 64'(e));
        end
    endtask

    task automatic do_ack();
        ext_if.ext_ack = 1'b1;
        tick();
        ext_if.ext_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ext_if.ext_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_active",  64'(ext_if.ext_active), 64'd0);
        chk("rst_num",     64'(ext_if.ext_num),    64'd0);
        chk("rst_clear",   64'(clear),             64'd0);
        chk("rst_pending", 64'(pending),           64'd0);

        // single edge source 5: exact latency and release
        irq_req[5] = 1'b1;
        exp_q.push_back(5);
        tick();
        irq_req[5] = 1'b0;
        chk("lat_e0_active", 64'(ext_if.ext_active), 64'd0);
        tick();
        chk("lat_e1_active", 64'(ext_if.ext_active), 64'd0);
        tick();
        chk("lat_e2_pending5", 64'(pending[5]), 64'd1);
        chk("lat_e2_active", 64'(ext_if.ext_active), 64'd0);
        tick();
        chk("lat_e3_active", 64'(ext_if.ext_active), 64'd1);
        check_grant("edge5_num");
        do_ack();
        chk("edge5_clear",    64'(clear),              64'h20);
        chk("edge5_pending",  64'(pending[5]),         64'd0);
        chk("edge5_hold1",    64'(ext_if.ext_active),  64'd0);
        tick();
        chk("edge5_clear_end", 64'(clear),             64'd0);
        chk("edge5_hold2",    64'(ext_if.ext_active),  64'd0);
        tick();
        chk("edge5_idle",     64'(ext_if.ext_active),  64'd0);

        // priority: 3 beats 9
        irq_req[9] = 1'b1;
        irq_req[3] = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(9);
        wait_active(10, n);
        check_grant("prio_first");
        irq_req[9] = 1'b0;
        irq_req[3] = 1'b0;
        do_ack();
        chk("prio_clear3", 64'(clear), 64'h8);
        wait_active(10, n);
        chk("prio_holdoff_gap", 64'(n), 64'd3);
        check_grant("prio_second");
        do_ack();
        chk("prio_clear9", 64'(clear), 64'h200);
        repeat (2) tick();

        // mask on level source 2
        irq_en[2]  = 1'b0;
        irq_req[2] = 1'b1;
        repeat (5) tick();
        chk("mask_active",   64'(ext_if.ext_active), 64'd0);
        chk("mask_pending2", 64'(pending[2]),        64'd1);
        irq_en[2] = 1'b1;
        exp_q.push_back(2);
        tick();
        chk("unmask_active", 64'(ext_if.ext_active), 64'd1);
        check_grant("unmask_num");
        irq_req[2] = 1'b0;
        do_ack();
        chk("unmask_clear", 64'(clear), 64'h4);
        repeat (4) tick();
        chk("level_dropped_active", 64'(ext_if.ext_active), 64'd0);

        // new edge on 7 lands in the same cycle as its acceptance clear
        irq_req[7] = 1'b1;
        exp_q.push_back(7);
        tick();
        irq_req[7] = 1'b0;
        wait_active(10, n);
        check_grant("edge7_first");
        irq_req[7] = 1'b1;
        exp_q.push_back(7);
        tick();
        irq_req[7] = 1'b0;
        tick();
        do_ack();
        chk("edge7_clear",   64'(clear),             64'h80);
        chk("edge7_kept",    64'(pending[7]),        64'd1);
        chk("edge7_hold",    64'(ext_if.ext_active), 64'd0);
        wait_active(10, n);
        chk("edge7_gap", 64'(n), 64'd3);
        check_grant("edge7_second");
        do_ack();
        chk("edge7_cleared", 64'(pending[7]), 64'd0);
        repeat (2) tick();

        // committed request on level source 12
        irq_req[12] = 1'b1;
        exp_q.push_back(12);
        wait_active(10, n);
        check_grant("commit_num");
        irq_req[12] = 1'b0;
        irq_en[12]  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("commit_active",   64'(ext_if.ext_active), 64'd1);
            chk("commit_num_hold", 64'(ext_if.ext_num),    64'd12);
        end
        do_ack();
        irq_en[12] = 1'b1;
        chk("commit_clear", 64'(clear), 64'h1000);
        repeat (4) tick();
        chk("commit_idle", 64'(ext_if.ext_active), 64'd0);
        do_ack();
        chk("stray_ack_clear",  64'(clear),             64'd0);
        chk("stray_ack_active", 64'(ext_if.ext_active), 64'd0);
        tick();
        chk("stray_ack_later",  64'(ext_if.ext_active), 64'd0);

        // async reset mid-REQ discards pending
        irq_req[5] = 1'b1;
        exp_q.push_back(5);
        tick();
        irq_req[5] = 1'b0;
        wait_active(10, n);
        check_grant("prereset_num");
        irq_req[9] = 1'b1;
        repeat (3) tick();
        chk("prereset_pending9", 64'(pending[9]),        64'd1);
        chk("prereset_active",   64'(ext_if.ext_active), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_active",  64'(ext_if.ext_active), 64'd0);
        chk("async_rst_pending", 64'(pending),           64'd0);
        tick();
        rst        = 1'b0;
        irq_req[9] = 1'b0;
        tick();
        chk("post_rst_active",  64'(ext_if.ext_active), 64'd0);
        chk("post_rst_num",     64'(ext_if.ext_num),    64'd0);
        chk("post_rst_clear",   64'(clear),             64'd0);
        chk("post_rst_pending", 64'(pending),           64'd0);

        // synchronous clear takes effect at the next edge
        irq_req[3] = 1'b1;
        exp_q.push_back(3);
        wait_active(10, n);
        check_grant("presync_num");
        irq_req[3] = 1'b0;
        rst_sync   = 1'b1;
        #2;
        chk("sync_rst_before_edge", 64'(ext_if.ext_active), 64'd1);
        tick();
        rst_sync = 1'b0;
        chk("sync_rst_active",  64'(ext_if.ext_active), 64'd0);
        chk("sync_rst_pending", 64'(pending),           64'd0);
        chk("sync_rst_num",     64'(ext_if.ext_num),    64'd0);
        repeat (4) tick();
        chk("sync_rst_idle",    64'(ext_if.ext_active), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/external_irq_arbiter.md
# external_irq_arbiter

Collects asynchronous interrupt request lines from peripheral devices, synchronises and latches them, and selects one pending source by fixed priority. Presents the selected source to the core's interrupt controller over the external interrupt handshake (active/number/ack). Sits directly upstream of the interrupt controller's `iEXT_ACTIVE` / `iEXT_NUM` / `oEXT_ACK` port group. Holds each request until that controller accepts it.

## Interface
Parameters:
- `NUM_SRC`, default 32: number of request lines; legal range 1..60, because the downstream adds 4 to the 6-bit number.
- `EDGE_SENSE`, default all-zero (`NUM_SRC` bits): per-source mode; 1 = rising-edge latched, 0 = level.

Ports:
- `iCLOCK`  in  1  — single clock; all state on its rising edge.
- `iRESET`  in  1  — asynchronous, active-high reset.
- `iRESET_SYNC`  in  1  — synchronous clear, same effect as `iRESET`, applied at the clock edge.
- `iIRQ_REQ`  in  `NUM_SRC`  — device request lines, asynchronous to `iCLOCK`.
- `iIRQ_ENABLE`  in  `NUM_SRC`  — per-source enable, synchronous; 0 blocks selection but does not discard edge-latched pending.
- `oIRQ_PENDING`  out  `NUM_SRC`  — current pending vector (status).
- `oIRQ_CLEAR`  out  `NUM_SRC`  — one-hot, one-cycle pulse to the source whose request was accepted.
- `oEXT_ACTIVE`  out  1  — request valid to the interrupt controller.
- `oEXT_NUM`  out  6  — selected source index, zero-extended.
- `iEXT_ACK`  in  1  — one-cycle acceptance pulse from the interrupt controller.

## Operation
- **Synchronisation**
  - Each `iIRQ_REQ` bit passes through a 2-flop synchroniser, giving `sync`.
  - A third flop holds `sync_d` for edge detection.
- **Pending**
  - Level source: `pending[i] = sync[i]`.
  - Edge source: `pending[i]` is set when `sync[i] & !sync_d[i]`, and cleared when source `i` is accepted.
  - If a set and a clear hit the same cycle, set wins, so a new edge is never lost.
  - Repeated edges while pending is already set merge into one request.
- **Candidate vector:** `cand = pending & iIRQ_ENABLE`. Priority is fixed: the lowest index wins.
- **FSM states**
  - `IDLE`
    - `oEXT_ACTIVE=0`.
    - If `cand != 0`, register the winner in `b_num` and go to `REQ`.
  - `REQ`
    - `oEXT_ACTIVE=1`, `oEXT_NUM=b_num`, both held stable.
    - The request is committed: dropping the enable, or a level source deasserting, does not withdraw it.
    - On `iEXT_ACK`: pulse `oIRQ_CLEAR[b_num]` for the next cycle, clear the edge pending bit, and go to `HOLDOFF`.
  - `HOLDOFF`
    - `oEXT_ACTIVE=0` for exactly 2 cycles; a 1-bit counter runs, then the FSM returns to `IDLE`.
    - Purpose: the downstream must see active low before it can re-arm, so one request is never captured twice.
  - Any illegal encoding returns to `IDLE`.
- **Unexpected acks:** `iEXT_ACK` in `IDLE` or `HOLDOFF` is ignored.
- **Level sources after acceptance:** a level source still asserted after `HOLDOFF` is selected again. The device must drop its line in response to `oIRQ_CLEAR`.
- **`oEXT_NUM` outside `REQ`:** it holds the last `b_num`; it is not meaningful while `oEXT_ACTIVE=0`.

## Timing
- **Reset values** (under `iRESET` or `iRESET_SYNC`):
  - `oEXT_ACTIVE=0`, `oEXT_NUM=0`, `oIRQ_CLEAR=0`, `oIRQ_PENDING=0`.
  - All synchroniser and `sync_d` flops are 0; FSM is in `IDLE`.
- **Reset mid-operation** (in `REQ` or `HOLDOFF`): `oEXT_ACTIVE` drops immediately on async reset, or at the next edge for `iRESET_SYNC`, and all pending is discarded.
- **Latency**
  - Request rises before edge E0, with setup met.
  - `sync` = 1 after E1.
  - Pending is visible on `oIRQ_PENDING` after E2 (level: after E1 via `sync`; edge: registered at E2).
  - `oEXT_ACTIVE=1` after E3.
- **Ack to release**
  - `iEXT_ACK` sampled high at edge A.
  - `oEXT_ACTIVE=0` and `oIRQ_CLEAR` pulse after A; the pulse lasts one cycle.
  - Next `oEXT_ACTIVE` no earlier than after A+3.
- **Throughput:** at most one accepted request per 4 cycles with back-to-back acks.

## Test plan
1. **Reset values:** assert `iRESET` async mid-cycle while in `REQ` → `oEXT_ACTIVE` drops at once; after release, all outputs are 0 and `IDLE`.
2. **Single edge source (index 5):** pulse `iIRQ_REQ[5]` for 1 cycle, all enabled → `oEXT_ACTIVE` after 3 edges with `oEXT_NUM=5`. Ack → `oIRQ_CLEAR=1<<5` for one cycle, pending[5]=0, then 2 holdoff cycles.
3. **Priority:** assert sources 9 and 3 together → `oEXT_NUM=3` first. After ack and holdoff → `oEXT_NUM=9`.
4. **Mask:** source 2 pending with `iIRQ_ENABLE[2]=0` → no `oEXT_ACTIVE` and `oIRQ_PENDING[2]=1`. Set enable → request appears next cycle with `oEXT_NUM=2`.
5. **Edge during clear:** a new edge on source 7 synchronised in the same cycle as its ack-clear → pending[7] stays 1; a second request for 7 appears after holdoff.
6. **Committed request:** hold `oEXT_ACTIVE` for 10 cycles without ack while the source deasserts and its enable drops → `oEXT_ACTIVE` and `oEXT_NUM` stay stable. An ack seen in `IDLE` has no effect.
